vga_scan_driver: RTL

- Initiator side of the pixel-query interface used by the tile/sprite colour ROMs.
- Generates 640x480@60 VGA timing from the system clock and drives 10-bit px/py pixel coordinates to a combinational colour source.
- Samples the returned 3-bit col into registered RGB outputs, with hsync/vsync/video_on delayed to stay pixel-aligned.
- Sits between the sprite/tile colour mux and the board VGA pins; also emits a frame_start pulse for game-logic update.

---
 rtl/vga_scan_driver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vga_scan_driver.sv
// VGA raster scan driver: pixel divider, h/v counters and a registered output stage
// that turns the colour source's answer into pixel-aligned rgb/hsync/vsync/video_on.
module vga_scan_driver #(
  parameter int DIV      = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] px,
  output logic [9:0] py,
  input  logic [2:0] col,
  output logic [2:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0]    V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_FIRST  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_cnt_r;
  logic [9:0]    hcnt_r;
  logic [9:0]    vcnt_r;
  logic [9:0]    hcnt_nxt_s;
  logic [9:0]    vcnt_nxt_s;
  logic          pix_tick_s;
  logic          active_s;
  logic          hsync_nxt_s;
  logic          vsync_nxt_s;
  logic          last_pix_s;
  logic [2:0]    rgb_r;
  logic          hsync_r;
  logic          vsync_r;
  logic          video_on_r;
  logic          frame_start_r;

  assign pix_tick_s = (div_cnt_r == DIV_LAST);

  // Clock divider: one pixel period every DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
    end else if (pix_tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

  // Next raster position; only a pixel tick moves the scan.
  always_comb begin
    hcnt_nxt_s = hcnt_r;
    vcnt_nxt_s = vcnt_r;
    if (pix_tick_s) begin
      if (hcnt_r == H_LAST) begin
        hcnt_nxt_s = 10'd0;
        if (vcnt_r == V_LAST) begin
          vcnt_nxt_s = 10'd0;
        end else begin
          vcnt_nxt_s = vcnt_r + 10'd1;
        end
      end else begin
        hcnt_nxt_s = hcnt_r + 10'd1;
      end
    end else begin
      hcnt_nxt_s = hcnt_r;
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_r <= 10'd0;
      vcnt_r <= 10'd0;
    end else begin
      hcnt_r <= hcnt_nxt_s;
      vcnt_r <= vcnt_nxt_s;
    end
  end

  // Decode of the pixel currently presented on px/py (pre-advance values).
  always_comb begin
    active_s    = (hcnt_r < H_VIS) && (vcnt_r < V_VIS);
    hsync_nxt_s = ~((hcnt_r >= HS_FIRST) && (hcnt_r <= HS_LAST));
    vsync_nxt_s = ~((vcnt_r >= VS_FIRST) && (vcnt_r <= VS_LAST));
    last_pix_s  = (hcnt_r == H_LAST) && (vcnt_r == V_LAST);
  end

  // Output stage: captures the answer for the current pixel as the scan advances,
  // giving exactly one pixel period of latency for all four outputs together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r      <= 3'b000;
      video_on_r <= 1'b0;
      hsync_r    <= 1'b1;
      vsync_r    <= 1'b1;
    end else if (pix_tick_s) begin
      rgb_r      <= active_s ? col : 3'b000;
      video_on_r <= active_s;
      hsync_r    <= hsync_nxt_s;
      vsync_r    <= vsync_nxt_s;
    end else begin
      rgb_r      <= rgb_r;
      video_on_r <= video_on_r;
      hsync_r    <= hsync_r;
      vsync_r    <= vsync_r;
    end
  end

  // Frame wrap pulse, one clock wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pix_tick_s && last_pix_s;
    end
  end

  assign px          = hcnt_r;
  assign py          = vcnt_r;
  assign pix_tick    = pix_tick_s;
  assign rgb         = rgb_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign video_on    = video_on_r;
  assign frame_start = frame_start_r;

endmodule
